// File: rtl/ifetch_sram_pkg.sv
// Shared types and constants for the instruction-fetch SRAM responder.
package ifetch_sram_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  localparam logic [31:0] RESET_PC            = 32'h8000_0000;
  localparam int unsigned DEFAULT_LATENCY     = 2;
  localparam int unsigned DEFAULT_DEPTH_WORDS = 1024;

  // True when addr is misaligned or falls outside [base, base + 4*depth_words).
  // Works on the offset so base + size never needs to be formed (no overflow).
  function automatic logic addr_bad(input logic [31:0] addr, input logic [31:0] base,
                                    input int unsigned depth_words);
    logic [31:0] off;
    off = addr - base;
    return (addr < base) || (off[1:0] != 2'b00) || ((off >> 2) >= depth_words);
  endfunction

endpackage

// File: rtl/ifetch_sram_array.sv
// Word-wide instruction storage: synchronous write, combinational read,
// and a write-first bypass so a same-cycle write is visible on the read port.
module ifetch_sram_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Preload port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read with write-first forwarding.
  always_comb begin
    rdata = mem[raddr];
    if (we && (waddr == raddr)) begin
      rdata = wdata;
    end
  end

endmodule

// File: rtl/ifetch_sram.sv
// Single-outstanding instruction-fetch responder with a fixed wait latency.
// The word is sampled on accept, so later preload writes cannot disturb it.
module ifetch_sram
  import ifetch_sram_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = RESET_PC,
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int unsigned LATENCY     = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic          req_bad;
  logic          ld_we;
  logic [AW-1:0] req_idx;
  logic [AW-1:0] ld_idx;
  logic [31:0]   rd_data;

  assign req_bad = addr_bad(req_addr, ADDR_BASE, DEPTH_WORDS);
  assign ld_we   = ld_en && !addr_bad(ld_addr, ADDR_BASE, DEPTH_WORDS);
  assign req_idx = AW'((req_addr - ADDR_BASE) >> 2);
  assign ld_idx  = AW'((ld_addr - ADDR_BASE) >> 2);

  ifetch_sram_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .we   (ld_we),
    .waddr(ld_idx),
    .wdata(ld_data),
    .raddr(req_idx),
    .rdata(rd_data)
  );

  // State, wait counter and captured request/response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= ADDR_BASE;
      data_q  <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic: capture on accept, count down, hold until handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d  = req_addr;
          data_d  = req_bad ? 32'h0000_0000 : rd_data;
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY == 0) ? StResp : StWait;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = data_q;
  // Error is re-derived from the captured address; the reset address is legal.
  assign rsp_err   = (state_q == StResp) && addr_bad(addr_q, ADDR_BASE, DEPTH_WORDS);

endmodule

// File: tb/tb_ifetch_sram.sv
// Directed self-checking bench for ifetch_sram (default 1024-word, latency 2).
module tb_ifetch_sram;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;

  int n_checks = 0;
  int n_errors = 0;

  ifetch_sram #(
    .ADDR_BASE  (32'h8000_0000),
    .DEPTH_WORDS(1024),
    .LATENCY    (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    step();
    ld_en = 1'b0;
  endtask

  // Present a request for one cycle; scramble the address afterwards.
  task automatic issue(input logic [31:0] a);
    check("req_ready_before_issue", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_addr = a;
    step();
    req_valid = 1'b0; req_addr = 32'hFFFF_FFF3;
  endtask

  // Cycles counted from the accept cycle until rsp_valid is seen.
  task automatic wait_rsp(output int cyc);
    cyc = 1;
    while (!rsp_valid && cyc < 20) begin
      step();
      cyc++;
    end
    if (!rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
  endtask

  // Full transaction with rsp_ready held high.
  task automatic fetch(input string tag, input logic [31:0] a,
                       input logic [31:0] exp_data, input logic exp_err);
    int cyc;
    issue(a);
    wait_rsp(cyc);
    check({tag, "_data"}, rsp_data, exp_data);
    check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    step();
    check({tag, "_idle"}, {30'd0, req_ready, rsp_valid}, 32'd2);
  endtask

  initial begin
    int cyc;
    logic [31:0] held;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = 32'h0; rsp_ready = 1'b1;
    ld_en = 1'b0; ld_addr = 32'h0; ld_data = 32'h0;
    repeat (2) step();
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'h0);
    rst_n = 1'b1;
    step();

    // Basic fetch and latency.
    preload(32'h8000_0000, 32'h0000_0413);
    issue(32'h8000_0000);
    wait_rsp(cyc);
    check("lat", cyc, 32'd3);
    check("basic_data", rsp_data, 32'h0000_0413);
    check("basic_err", {31'd0, rsp_err}, 32'd0);
    step();
    check("basic_idle", {30'd0, req_ready, rsp_valid}, 32'd2);

    // Error cases and last valid word.
    fetch("misalign", 32'h8000_0002, 32'h0, 1'b1);
    fetch("below", 32'h7FFF_FFFC, 32'h0, 1'b1);
    fetch("above", 32'h8000_1000, 32'h0, 1'b1);
    preload(32'h8000_0FFC, 32'hA5A5_0FFC);
    fetch("last_word", 32'h8000_0FFC, 32'hA5A5_0FFC, 1'b0);

    // Back-pressure: response holds for five cycles.
    preload(32'h8000_0004, 32'h1234_5678);
    rsp_ready = 1'b0;
    issue(32'h8000_0004);
    wait_rsp(cyc);
    held = rsp_data;
    check("stall_data0", held, 32'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_data", rsp_data, 32'h1234_5678);
      check("stall_err", {31'd0, rsp_err}, 32'd0);
      check("stall_req_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    check("stall_release", {30'd0, req_ready, rsp_valid}, 32'd2);

    // Write-first on the accept cycle.
    preload(32'h8000_0010, 32'h1111_1111);
    req_valid = 1'b1; req_addr = 32'h8000_0010;
    ld_en = 1'b1; ld_addr = 32'h8000_0010; ld_data = 32'hDEAD_BEEF;
    step();
    req_valid = 1'b0; ld_en = 1'b0;
    wait_rsp(cyc);
    check("wfirst_data", rsp_data, 32'hDEAD_BEEF);
    step();

    // Write during WAIT does not alter the captured word, but does land.
    issue(32'h8000_0010);
    preload(32'h8000_0010, 32'hCAFE_F00D);
    wait_rsp(cyc);
    check("wait_wr_data", rsp_data, 32'hDEAD_BEEF);
    step();
    fetch("wait_wr_landed", 32'h8000_0010, 32'hCAFE_F00D, 1'b0);

    // Illegal preload addresses that alias word 4 must be dropped.
    preload(32'h8000_0011, 32'h5555_5555);
    preload(32'h8000_1010, 32'h6666_6666);
    fetch("ld_drop", 32'h8000_0010, 32'hCAFE_F00D, 1'b0);

    // Reset during WAIT aborts; array survives reset.
    issue(32'h8000_0000);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
    check("abort_req_ready", {31'd0, req_ready}, 32'd1);
    check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("abort_quiet", {30'd0, req_ready, rsp_valid}, 32'd2);
    end
    fetch("after_reset", 32'h8000_0000, 32'h0000_0413, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
